alarm_unit: RTL and testbench
=============================

// Module: alarm_unit
// PURPOSE
//  Alarm stage downstream of the timekeeping counters. Consumes the live BCD HH:MM and the 1 Hz
//  tick, holds a user-set BCD alarm time, fires on match and runs the ring/snooze/timeout sequence.
//  Drives a buzzer square wave, and status flags for the display and decimal-point logic.
// PARAMETERS
//  TONE_DIV    5   clk_in cycles per buzzer half-period (>=1)
//  RING_SECS   60  seconds of ringing before automatic silence (>=1)
//  SNOOZE_SECS 300 seconds in SNOOZE before re-ringing (>=1)
// PORTS
//  clk_in     in   1   system clock (PLL output)
//  reset      in   1   asynchronous, active-high reset
//  tick_1hz   in   1   single-cycle enable pulse, once per second, synchronous to clk_in
//  cur_time   in   14  live time {hour_tens[1:0], hour_ones[3:0], min_tens[3:0], min_ones[3:0]} BCD
//  alarm_en   in   1   level: alarm armed
//  set_mode   in   1   level: alarm-time edit mode
//  inc_hour   in   1   single-cycle pulse: increment alarm hour (edit mode only)
//  inc_min    in   1   single-cycle pulse: increment alarm minute (edit mode only)
//  snooze     in   1   single-cycle pulse: snooze request
//  stop       in   1   single-cycle pulse: silence alarm
//  alarm_time out  14  stored alarm time, same packing as cur_time
//  ringing    out  1   high in RINGING
//  snoozed    out  1   high in SNOOZE
//  buzzer     out  1   tone output; 0 outside RINGING
// BEHAVIOUR
//  Reset (async, any time, mid-ring included): state IDLE; alarm_time=06:00 {2'd0,4'd6,4'd0,4'd0};
//   ringing=0, snoozed=0, buzzer=0, fired=0, all counters 0. All outputs registered.
//  Edit (set_mode=1): inc_min: min_ones+1; 9->0 with min_tens+1; 59->00, no carry into hour.
//   inc_hour: 09->10, 19->20, 23->00. Both pulses same cycle: both apply. Pulses ignored if set_mode=0.
//  match = (cur_time == alarm_time). fired latch: set on trigger; cleared any cycle match=0.
//  FSM, priority per cycle: set_mode > !alarm_en > stop > snooze > tick events.
//   IDLE:    tick_1hz & match & !fired & alarm_en & !set_mode -> RINGING (ring_cnt=0, fired=1).
//   RINGING: set_mode | !alarm_en | stop -> IDLE. snooze -> SNOOZE (snz_cnt=0).
//            tick_1hz: ring_cnt+1; tick with ring_cnt==RING_SECS-1 -> IDLE.
//   SNOOZE:  set_mode | !alarm_en | stop -> IDLE.
//            tick_1hz: snz_cnt+1; tick with snz_cnt==SNOOZE_SECS-1 -> RINGING (ring_cnt=0).
//  Latency: ringing/snoozed change the cycle after the causing event; trigger tick cycle+1.
//  Minute-wide match ticks fire once per minute only (fired); stop/timeout in the alarm minute
//   does not re-fire; alarm_time edited onto current minute fires on next tick if armed.
//  Buzzer: tone_cnt and buzzer cleared on RINGING entry; in RINGING tone_cnt counts 0..TONE_DIV-1,
//   buzzer toggles on wrap (period 2*TONE_DIV). Leaving RINGING forces buzzer=0 next cycle.
//  Counter widths $clog2 of their limits; no overflow possible.
// TESTING
//  1) Reset, alarm_en=1, cur_time=06:00, tick -> ringing=1 next cycle; buzzer toggles every 5 clk.
//  2) Ringing, hold 60 ticks -> ringing=0 after 60th; further ticks at 06:00 -> no re-fire.
//  3) Ringing, snooze pulse -> snoozed=1, buzzer=0; 300 ticks -> ringing=1, snoozed=0.
//  4) set_mode=1: 9x inc_min from 00 -> 09; +1 -> 10; from 59 -> 00, hour unchanged; 23 inc_hour -> 00.
//  5) Ringing with stop and snooze same cycle -> IDLE; alarm_en=0 during SNOOZE -> IDLE.
//  6) Assert reset mid-RINGING between clk edges -> outputs 0 immediately, alarm_time=06:00.

Source files
------------

// File: rtl/alarm_unit.sv
// Alarm stage: stores a BCD alarm time, fires when the live time matches it
// on a 1 Hz tick, and runs the ring / snooze / timeout sequence with a
// square-wave buzzer.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | armed or disarmed, waiting for a match on a 1 Hz tick
//   RINGING | buzzer active, counting seconds down to auto-silence
//   SNOOZE  | buzzer silent, counting seconds down to re-ring
module alarm_unit #(
  parameter int TONE_DIV    = 5,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic [13:0] cur_time,
  input  logic        alarm_en,
  input  logic        set_mode,
  input  logic        inc_hour,
  input  logic        inc_min,
  input  logic        snooze,
  input  logic        stop,
  output logic [13:0] alarm_time,
  output logic        ringing,
  output logic        snoozed,
  output logic        buzzer
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

  // A width of 1 keeps a limit of 1 legal; the counters only hold limit-1.
  localparam int TW = (TONE_DIV    > 1) ? $clog2(TONE_DIV)    : 1;
  localparam int RW = (RING_SECS   > 1) ? $clog2(RING_SECS)   : 1;
  localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS) : 1;

  state_t          state, state_nxt;
  logic [TW-1:0]   tone_cnt;
  logic [RW-1:0]   ring_cnt;
  logic [SW-1:0]   snz_cnt;
  logic [1:0]      am_ht;
  logic [3:0]      am_ho, am_mt, am_mo;
  logic            match, fired, trigger, abort;

  assign alarm_time = {am_ht, am_ho, am_mt, am_mo};
  assign match      = (cur_time == alarm_time);
  assign abort      = set_mode | ~alarm_en | stop;
  assign trigger    = (state == IDLE) & tick_1hz & match & ~fired & alarm_en & ~set_mode;

  // Alarm-time editing: BCD minute wraps 59->00 without hour carry, hour wraps 23->00.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      am_ht <= 2'd0;
      am_ho <= 4'd6;
      am_mt <= 4'd0;
      am_mo <= 4'd0;
    end else if (set_mode) begin
      if (inc_min) begin
        if (am_mo == 4'd9) begin
          am_mo <= 4'd0;
          am_mt <= (am_mt == 4'd5) ? 4'd0 : am_mt + 4'd1;
        end else begin
          am_mo <= am_mo + 4'd1;
        end
      end
      if (inc_hour) begin
        if (am_ht == 2'd2 && am_ho == 4'd3) begin
          am_ht <= 2'd0;
          am_ho <= 4'd0;
        end else if (am_ho == 4'd9) begin
          am_ho <= 4'd0;
          am_ht <= am_ht + 2'd1;
        end else begin
          am_ho <= am_ho + 4'd1;
        end
      end
    end
  end

  // Once-per-minute latch: blocks re-firing until the live time leaves the alarm minute.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)         fired <= 1'b0;
    else if (trigger)  fired <= 1'b1;
    else if (!match)   fired <= 1'b0;
  end

  // State register plus registered status flags derived from the next state.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ringing <= 1'b0;
      snoozed <= 1'b0;
    end else begin
      state   <= state_nxt;
      ringing <= (state_nxt == RINGING);
      snoozed <= (state_nxt == SNOOZE);
    end
  end

  // Next-state decode; abort conditions outrank snooze, which outranks tick events.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trigger) state_nxt = RINGING;
      end
      RINGING: begin
        if (abort)                                state_nxt = IDLE;
        else if (snooze)                          state_nxt = SNOOZE;
        else if (tick_1hz && ring_cnt == '0)      state_nxt = IDLE;
      end
      SNOOZE: begin
        if (abort)                                state_nxt = IDLE;
        else if (tick_1hz && snz_cnt == '0)       state_nxt = RINGING;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Second timers: loaded with limit-1 on entry, terminal count at zero.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      ring_cnt <= '0;
      snz_cnt  <= '0;
    end else begin
      if (state_nxt == RINGING && state != RINGING)
        ring_cnt <= RW'(RING_SECS - 1);
      else if (state == RINGING && tick_1hz && ring_cnt != '0)
        ring_cnt <= ring_cnt - RW'(1);
      if (state == RINGING && state_nxt == SNOOZE)
        snz_cnt <= SW'(SNOOZE_SECS - 1);
      else if (state == SNOOZE && tick_1hz && snz_cnt != '0)
        snz_cnt <= snz_cnt - SW'(1);
    end
  end

  // Tone generator: buzzer toggles every TONE_DIV cycles while ringing, forced low otherwise.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (state_nxt != RINGING) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if (state != RINGING) begin
      tone_cnt <= TW'(TONE_DIV - 1);
      buzzer   <= 1'b0;
    end else if (tone_cnt == '0) begin
      tone_cnt <= TW'(TONE_DIV - 1);
      buzzer   <= ~buzzer;
    end else begin
      tone_cnt <= tone_cnt - TW'(1);
    end
  end

endmodule

// File: tb/tb_alarm_unit.sv
// Directed bench for alarm_unit: reset values, firing, buzzer period,
// timeout, snooze, edit arithmetic, abort priority and async reset.
module tb_alarm_unit;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        tick_1hz, alarm_en, set_mode, inc_hour, inc_min, snooze, stop;
  logic [13:0] cur_time, alarm_time;
  logic        ringing, snoozed, buzzer;

  int n_cmp = 0;
  int n_err = 0;

  alarm_unit dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .cur_time   (cur_time),
    .alarm_en   (alarm_en),
    .set_mode   (set_mode),
    .inc_hour   (inc_hour),
    .inc_min    (inc_min),
    .snooze     (snooze),
    .stop       (stop),
    .alarm_time (alarm_time),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .buzzer     (buzzer)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic edit(input logic m, input logic h, input int n = 1);
    for (int i = 0; i < n; i++) begin
      inc_min  = m;
      inc_hour = h;
      step();
      inc_min  = 1'b0;
      inc_hour = 1'b0;
    end
  endtask

  // Leave the alarm minute briefly so the once-per-minute latch clears, then fire at 06:00.
  task automatic refire();
    cur_time = 14'h0601;
    step();
    cur_time = 14'h0600;
    step();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    {tick_1hz, alarm_en, set_mode, inc_hour, inc_min, snooze, stop} = '0;
    cur_time = 14'h0000;
    step(2);
    chk("rst_alarm_time", {2'b0, alarm_time}, 16'h0600);
    chk("rst_ringing",    {15'b0, ringing},   16'h0);
    chk("rst_snoozed",    {15'b0, snoozed},   16'h0);
    chk("rst_buzzer",     {15'b0, buzzer},    16'h0);
    reset = 1'b0;
    step();

    // 1) fire one cycle after the tick, buzzer half-period of 5 clocks
    alarm_en = 1'b1;
    cur_time = 14'h0600;
    step();
    chk("no_fire_without_tick", {15'b0, ringing}, 16'h0);
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk("fire_ringing", {15'b0, ringing}, 16'h1);
    chk("fire_buzzer0", {15'b0, buzzer},  16'h0);
    step(4);
    chk("buzz_before_5", {15'b0, buzzer}, 16'h0);
    step(1);
    chk("buzz_at_5",     {15'b0, buzzer}, 16'h1);
    step(4);
    chk("buzz_before_10", {15'b0, buzzer}, 16'h1);
    step(1);
    chk("buzz_at_10",    {15'b0, buzzer}, 16'h0);

    // 2) auto-silence on the 60th tick, no re-fire within the same minute
    tick(59);
    chk("ring_after_59", {15'b0, ringing}, 16'h1);
    tick(1);
    chk("silent_after_60", {15'b0, ringing}, 16'h0);
    chk("silent_buzzer",   {15'b0, buzzer},  16'h0);
    tick(3);
    chk("no_refire_same_minute", {15'b0, ringing}, 16'h0);

    // 3) snooze for 300 seconds then re-ring
    refire();
    chk("refire_ringing", {15'b0, ringing}, 16'h1);
    step(5);
    chk("refire_buzz_hi", {15'b0, buzzer}, 16'h1);
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snooze_snoozed", {15'b0, snoozed}, 16'h1);
    chk("snooze_ringing", {15'b0, ringing}, 16'h0);
    chk("snooze_buzzer",  {15'b0, buzzer},  16'h0);
    tick(299);
    chk("snooze_after_299", {15'b0, snoozed}, 16'h1);
    tick(1);
    chk("rering_ringing", {15'b0, ringing}, 16'h1);
    chk("rering_snoozed", {15'b0, snoozed}, 16'h0);

    // 5) stop outranks snooze; disarming during snooze returns to idle
    stop   = 1'b1;
    snooze = 1'b1;
    step();
    stop   = 1'b0;
    snooze = 1'b0;
    chk("stop_snooze_ringing", {15'b0, ringing}, 16'h0);
    chk("stop_snooze_snoozed", {15'b0, snoozed}, 16'h0);
    refire();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("snooze_again", {15'b0, snoozed}, 16'h1);
    alarm_en = 1'b0;
    step();
    alarm_en = 1'b1;
    chk("disarm_in_snooze", {15'b0, snoozed}, 16'h0);
    chk("disarm_no_ring",   {15'b0, ringing}, 16'h0);

    // 4) edit arithmetic
    edit(1'b1, 1'b0);
    chk("inc_ignored_no_set", {2'b0, alarm_time}, 16'h0600);
    set_mode = 1'b1;
    edit(1'b1, 1'b0, 9);
    chk("min_09", {2'b0, alarm_time}, 16'h0609);
    edit(1'b1, 1'b0);
    chk("min_10", {2'b0, alarm_time}, 16'h0610);
    edit(1'b1, 1'b0, 49);
    chk("min_59", {2'b0, alarm_time}, 16'h0659);
    edit(1'b1, 1'b0);
    chk("min_wrap_no_carry", {2'b0, alarm_time}, 16'h0600);
    edit(1'b0, 1'b1, 3);
    chk("hour_09", {2'b0, alarm_time}, 16'h0900);
    edit(1'b0, 1'b1);
    chk("hour_10", {2'b0, alarm_time}, 16'h1000);
    edit(1'b0, 1'b1, 10);
    chk("hour_20", {2'b0, alarm_time}, 16'h2000);
    edit(1'b0, 1'b1, 3);
    chk("hour_23", {2'b0, alarm_time}, 16'h2300);
    edit(1'b0, 1'b1);
    chk("hour_wrap", {2'b0, alarm_time}, 16'h0000);
    edit(1'b1, 1'b1);
    chk("both_inc", {2'b0, alarm_time}, 16'h0101);
    cur_time = 14'h0101;
    tick(1);
    chk("no_fire_in_set_mode", {15'b0, ringing}, 16'h0);
    set_mode = 1'b0;
    step();

    // alarm edited onto the current minute fires on the next tick
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
    chk("edited_fire", {15'b0, ringing}, 16'h1);
    step(5);
    chk("edited_buzz_hi", {15'b0, buzzer}, 16'h1);

    // 6) async reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_ringing",    {15'b0, ringing},   16'h0);
    chk("async_buzzer",     {15'b0, buzzer},    16'h0);
    chk("async_snoozed",    {15'b0, snoozed},   16'h0);
    chk("async_alarm_time", {2'b0, alarm_time}, 16'h0600);
    step();
    reset = 1'b0;
    step(2);
    chk("post_reset_idle", {15'b0, ringing}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
